// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB2 master shared by NUM_REQ local requesters
module apb_master_arbiter #(
    parameter int         NUM_REQ  = 2,
    parameter int         ADDR_W   = 32,
    parameter int         DATA_W   = 32,
    parameter logic [3:0] BASE_NIB = 4'h8
) (
    input  logic                      clock,
    input  logic                      Presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [3:0]                Pselx,
    output logic                      Penable,
    output logic                      Pwrite,
    output logic [DATA_W-1:0]         Pwdata,
    input  logic [DATA_W-1:0]         Prdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr, owner, grant_idx, next_ptr;
    logic [PTR_W:0]     probe, inc;
    logic               grant_valid, grant_hit, accept;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_wdata;
    logic [NUM_REQ-1:0] grant_onehot;

    // Scan from the highest offset down so the requester closest to rr_ptr wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            probe = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (probe >= NUM_REQ_W) probe = probe - NUM_REQ_W;
            if (req_valid[probe[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = probe[PTR_W-1:0];
            end
        end
    end

    assign inc          = {1'b0, grant_idx} + (PTR_W+1)'(1);
    assign next_ptr     = (inc == NUM_REQ_W) ? '0 : inc[PTR_W-1:0];
    assign grant_addr   = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign grant_wdata  = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    assign grant_hit    = (grant_addr[ADDR_W-1 -: 4] == BASE_NIB);
    assign grant_onehot = NUM_REQ'(1) << grant_idx;
    assign accept       = (state_q == IDLE) && grant_valid;
    assign req_ready    = accept ? grant_onehot : '0;

    always_ff @(posedge clock or negedge Presetn) begin
        if (!Presetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Select/enable derive from state so an async reset drops them at once.
    always_comb begin
        state_d = state_q;
        Pselx   = 4'b0000;
        Penable = 1'b0;
        case (state_q)
            IDLE:   if (accept && grant_hit) state_d = SETUP;
            SETUP: begin
                state_d = ACCESS;
                Pselx   = 4'b0001 << Paddr[ADDR_W-5 -: 2];
            end
            ACCESS: begin
                state_d = IDLE;
                Pselx   = 4'b0001 << Paddr[ADDR_W-5 -: 2];
                Penable = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge Presetn) begin
        if (!Presetn) begin
            rr_ptr    <= '0;
            owner     <= '0;
            Paddr     <= '0;
            Pwrite    <= 1'b0;
            Pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                owner  <= grant_idx;
                rr_ptr <= next_ptr;
                if (grant_hit) begin
                    Paddr  <= grant_addr;
                    Pwrite <= req_write[grant_idx];
                    Pwdata <= req_write[grant_idx] ? grant_wdata : '0;
                end else begin
                    // Decode miss: answer directly, bus stays untouched.
                    rsp_valid <= grant_onehot;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (state_q == ACCESS) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_err   <= 1'b0;
                rsp_rdata <= Pwrite ? '0 : Prdata;
            end
        end
    end

endmodule
